// File: rtl/hex_scan_display.sv
// Four-digit multiplexed hex display for an 8-bit debug byte and its change counter.
// Captures on sample_en, counts value changes, and flashes the decimal points after each change.
module hex_scan_display #(
  parameter int unsigned REFRESH_DIV    = 50000,
  parameter int unsigned DEAD_CYCLES    = 2,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sample_en,
  input  logic [7:0] value,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an,
  output logic       chg_pulse,
  output logic [7:0] chg_count
);

  localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_DEAD = CNT_W'(DEAD_CYCLES);

  // Everything below is built active-low, then flipped once for active-high boards.
  localparam logic [6:0] SEG_INV = SEG_ACTIVE_LOW ? 7'h00 : 7'h7F;
  localparam logic       DP_INV  = SEG_ACTIVE_LOW ? 1'b0  : 1'b1;
  localparam logic [3:0] AN_INV  = SEG_ACTIVE_LOW ? 4'h0  : 4'hF;

  localparam logic [2:0] FLASH_SLOTS = 3'd4;

  logic [7:0]       held_q, held_d;
  logic [7:0]       chg_count_q, chg_count_d;
  logic             chg_pulse_q, chg_pulse_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       d_q, d_d;
  logic [2:0]       flash_q, flash_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;
  logic [3:0]       an_q, an_d;

  logic       change;
  logic       wrap;
  logic       lit;
  logic [3:0] nibble;
  logic [6:0] glyph;

  always_comb begin
    change      = sample_en && (value != held_q);
    wrap        = (cnt_q == CNT_LAST);

    held_d      = sample_en ? value : held_q;
    chg_count_d = chg_count_q + 8'(change);
    chg_pulse_d = change;
    cnt_d       = wrap ? '0 : cnt_q + 1'b1;
    d_d         = wrap ? d_q + 2'd1 : d_q;

    // A fresh change always restarts the flash, even on a wrap edge.
    flash_d = flash_q;
    if (change) begin
      flash_d = FLASH_SLOTS;
    end else if (wrap && (flash_q != 3'd0)) begin
      flash_d = flash_q - 3'd1;
    end

    case (d_q)
      2'd0:    nibble = held_q[3:0];
      2'd1:    nibble = held_q[7:4];
      2'd2:    nibble = chg_count_q[3:0];
      default: nibble = chg_count_q[7:4];
    endcase

    case (nibble)
      4'h0:    glyph = 7'h40;
      4'h1:    glyph = 7'h79;
      4'h2:    glyph = 7'h24;
      4'h3:    glyph = 7'h30;
      4'h4:    glyph = 7'h19;
      4'h5:    glyph = 7'h12;
      4'h6:    glyph = 7'h02;
      4'h7:    glyph = 7'h78;
      4'h8:    glyph = 7'h00;
      4'h9:    glyph = 7'h10;
      4'hA:    glyph = 7'h08;
      4'hB:    glyph = 7'h03;
      4'hC:    glyph = 7'h46;
      4'hD:    glyph = 7'h21;
      4'hE:    glyph = 7'h06;
      default: glyph = 7'h0E;
    endcase

    lit   = (cnt_q >= CNT_DEAD);
    seg_d = glyph ^ SEG_INV;
    an_d  = (lit ? ~(4'b0001 << d_q) : 4'hF) ^ AN_INV;
    dp_d  = ~(lit && (flash_q != 3'd0)) ^ DP_INV;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      held_q      <= '0;
      chg_count_q <= '0;
      chg_pulse_q <= 1'b0;
      cnt_q       <= '0;
      d_q         <= '0;
      flash_q     <= '0;
      seg_q       <= 7'h7F ^ SEG_INV;
      dp_q        <= 1'b1 ^ DP_INV;
      an_q        <= 4'hF ^ AN_INV;
    end else begin
      held_q      <= held_d;
      chg_count_q <= chg_count_d;
      chg_pulse_q <= chg_pulse_d;
      cnt_q       <= cnt_d;
      d_q         <= d_d;
      flash_q     <= flash_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
      an_q        <= an_d;
    end
  end

  assign seg       = seg_q;
  assign dp        = dp_q;
  assign an        = an_q;
  assign chg_pulse = chg_pulse_q;
  assign chg_count = chg_count_q;

endmodule

// File: tb/tb_hex_scan_display.sv
// Bench for hex_scan_display with a 4-cycle slot and 1 dead cycle, active-low outputs.
// A slot/flash model computed from plain arithmetic predicts every output each cycle.
module tb_hex_scan_display;

  localparam int RD   = 4;
  localparam int DEAD = 1;

  logic       clk = 1'b0;
  logic       reset;
  logic       sample_en;
  logic [7:0] value;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;
  logic       chg_pulse;
  logic [7:0] chg_count;

  int vecs  = 0;
  int fails = 0;

  hex_scan_display #(
    .REFRESH_DIV    (RD),
    .DEAD_CYCLES    (DEAD),
    .SEG_ACTIVE_LOW (1'b1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .sample_en (sample_en),
    .value     (value),
    .seg       (seg),
    .dp        (dp),
    .an        (an),
    .chg_pulse (chg_pulse),
    .chg_count (chg_count)
  );

  always #5 clk = ~clk;

  logic [6:0] glyph_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Model state
  int         m_held, m_count, m_cnt, m_d, m_flash;
  logic       m_pulse;
  logic [6:0] e_seg;
  logic       e_dp;
  logic [3:0] e_an;

  // Apply one clock with the given inputs and advance the model across that edge.
  task automatic step(input logic r, input logic se, input logic [7:0] v);
    int nib;
    bit chg, wrp;
    @(negedge clk);
    reset = r; sample_en = se; value = v;
    @(posedge clk);
    #1;
    if (r) begin
      m_held = 0; m_count = 0; m_cnt = 0; m_d = 0; m_flash = 0; m_pulse = 1'b0;
      e_seg = 7'h7F; e_dp = 1'b1; e_an = 4'hF;
    end else begin
      case (m_d)
        0: nib = m_held % 16;
        1: nib = m_held / 16;
        2: nib = m_count % 16;
        default: nib = m_count / 16;
      endcase
      e_seg = glyph_tab[nib];
      e_an  = (m_cnt >= DEAD) ? 4'(15 - (1 << m_d)) : 4'hF;
      e_dp  = !((m_cnt >= DEAD) && (m_flash != 0));
      chg = se && (int'(v) != m_held);
      wrp = (m_cnt == RD - 1);
      m_cnt = wrp ? 0 : m_cnt + 1;
      if (wrp) m_d = (m_d + 1) % 4;
      if (chg) m_flash = 4;
      else if (wrp && m_flash > 0) m_flash = m_flash - 1;
      if (chg) m_count = (m_count + 1) % 256;
      if (se) m_held = int'(v);
      m_pulse = chg;
    end
  endtask

  task automatic test_reset();
    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h00);
    vecs++;
    if ({seg, dp, an, chg_pulse, chg_count} !== {7'h7F, 1'b1, 4'hF, 1'b0, 8'h00}) begin
      fails++;
      $display("FAIL reset_state: seg=%h dp=%b an=%h pulse=%b count=%h want 7f 1 f 0 00",
               seg, dp, an, chg_pulse, chg_count);
    end
  endtask

  task automatic test_idle_scan();
    logic [3:0] an_want [16] = '{4'hF, 4'hE, 4'hE, 4'hE, 4'hF, 4'hD, 4'hD, 4'hD,
                                 4'hF, 4'hB, 4'hB, 4'hB, 4'hF, 4'h7, 4'h7, 4'h7};
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b0, 8'h00);
      vecs++;
      if (an !== an_want[i] || (an != 4'hF && seg !== 7'h40) || dp !== 1'b1 || chg_pulse !== 1'b0) begin
        fails++;
        $display("FAIL idle_scan[%0d]: an=%h seg=%h dp=%b pulse=%b want an=%h seg=40 dp=1 pulse=0",
                 i, an, seg, dp, chg_pulse, an_want[i]);
      end
    end
  endtask

  task automatic test_capture_a5();
    logic [6:0] digit_want [4] = '{7'h12, 7'h08, 7'h79, 7'h40};
    bit seen [4];
    step(1'b0, 1'b1, 8'hA5);
    vecs++;
    if (chg_pulse !== 1'b1 || chg_count !== 8'h01) begin
      fails++;
      $display("FAIL capture_pulse: pulse=%b count=%h want 1 01", chg_pulse, chg_count);
    end
    for (int i = 0; i < 24; i++) begin
      step(1'b0, 1'b0, 8'h00);
      vecs++;
      if ({seg, dp, an, chg_pulse, chg_count} !== {e_seg, e_dp, e_an, m_pulse, 8'(m_count)}) begin
        fails++;
        $display("FAIL capture_scan[%0d]: seg=%h dp=%b an=%h pulse=%b count=%h want %h %b %h %b %h",
                 i, seg, dp, an, chg_pulse, chg_count, e_seg, e_dp, e_an, m_pulse, m_count[7:0]);
      end
      for (int k = 0; k < 4; k++) begin
        if (an == 4'(15 - (1 << k))) begin
          seen[k] = 1'b1;
          vecs++;
          if (seg !== digit_want[k]) begin
            fails++;
            $display("FAIL digit%0d_glyph: seg=%h want %h", k, seg, digit_want[k]);
          end
        end
      end
    end
    vecs++;
    if (!(seen[0] && seen[1] && seen[2] && seen[3])) begin
      fails++;
      $display("FAIL digit_coverage: seen=%b%b%b%b want 1111", seen[3], seen[2], seen[1], seen[0]);
    end
  endtask

  task automatic test_same_value();
    int flash_before;
    flash_before = m_flash;
    step(1'b0, 1'b1, 8'hA5);
    vecs++;
    if (chg_pulse !== 1'b0 || chg_count !== 8'h01 || m_flash != flash_before) begin
      fails++;
      $display("FAIL same_value: pulse=%b count=%h want 0 01", chg_pulse, chg_count);
    end
  endtask

  task automatic test_wrap_256();
    int pulses = 0;
    step(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 256; i++) begin
      step(1'b0, 1'b1, (i % 2 == 0) ? 8'hFF : 8'h00);
      if (chg_pulse === 1'b1) pulses++;
      step(1'b0, 1'b0, 8'h00);
      if (chg_pulse === 1'b1) pulses++;
    end
    vecs++;
    if (chg_count !== 8'h00 || pulses != 256) begin
      fails++;
      $display("FAIL count_wrap: count=%h pulses=%0d want 00 256", chg_count, pulses);
    end
  endtask

  task automatic test_reset_override();
    step(1'b0, 1'b1, 8'h77);
    step(1'b1, 1'b1, 8'h3C);
    vecs++;
    if ({seg, dp, an, chg_pulse, chg_count} !== {7'h7F, 1'b1, 4'hF, 1'b0, 8'h00}) begin
      fails++;
      $display("FAIL reset_override: seg=%h dp=%b an=%h pulse=%b count=%h want 7f 1 f 0 00",
               seg, dp, an, chg_pulse, chg_count);
    end
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00);
    vecs++;
    if (an !== 4'hE || seg !== 7'h40 || dp !== 1'b1) begin
      fails++;
      $display("FAIL post_reset_digit0: an=%h seg=%h dp=%b want e 40 1", an, seg, dp);
    end
  endtask

  task automatic test_change_on_wrap();
    int guard = 0;
    step(1'b0, 1'b1, 8'h11);
    while (!(m_flash == 1 && m_cnt == RD - 1) && guard < 100) begin
      step(1'b0, 1'b0, 8'h00);
      guard++;
    end
    vecs++;
    if (guard >= 100) begin
      fails++;
      $display("FAIL wrap_setup: no flash=1 wrap point found, got %0d want <100", guard);
    end
    step(1'b0, 1'b1, 8'h22);
    for (int i = 0; i < 4 * RD + RD; i++) begin
      step(1'b0, 1'b0, 8'h00);
      if (an != 4'hF) begin
        vecs++;
        if (dp !== ((i < 4 * RD) ? 1'b0 : 1'b1)) begin
          fails++;
          $display("FAIL wrap_reload_dp[%0d]: dp=%b want %b", i, dp, (i < 4 * RD) ? 1'b0 : 1'b1);
        end
      end
    end
  endtask

  task automatic test_random();
    logic r, se;
    logic [7:0] v;
    for (int i = 0; i < 600; i++) begin
      r  = ($urandom_range(0, 99) == 0);
      se = ($urandom_range(0, 3) == 0);
      v  = 8'($urandom_range(0, 3) * 8'h55);
      if ($urandom_range(0, 7) == 0) v = 8'($urandom);
      step(r, se, v);
      vecs++;
      if ({seg, dp, an, chg_pulse, chg_count} !== {e_seg, e_dp, e_an, m_pulse, 8'(m_count)}) begin
        fails++;
        $display("FAIL random[%0d]: seg=%h dp=%b an=%h pulse=%b count=%h want %h %b %h %b %h",
                 i, seg, dp, an, chg_pulse, chg_count, e_seg, e_dp, e_an, m_pulse, m_count[7:0]);
      end
    end
  endtask

  initial begin
    reset = 1'b1; sample_en = 1'b0; value = 8'h00;
    m_held = 0; m_count = 0; m_cnt = 0; m_d = 0; m_flash = 0; m_pulse = 1'b0;
    e_seg = 7'h7F; e_dp = 1'b1; e_an = 4'hF;
    test_reset();
    test_idle_scan();
    test_capture_a5();
    test_same_value();
    test_wrap_256();
    test_reset_override();
    test_change_on_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule
